// File: rtl/i3c_target_reset_ctrl.sv
// I3C target reset sequencer: HDR-mode tracking, RSTACT action decode, reset pulse generation.
// Latency: 1 cycle from target_reset_detect_i to reset pulse; pulse lasts PULSE_CYCLES cycles.
// Backpressure: none; all inputs are single-cycle pulses and are consumed or ignored on arrival.
//
// Ports:
//   clk_i, rst_i (sync, active-high), enable_i (low = soft reset of all state)
//   hdr_enter_i / hdr_exit_detect_i / target_reset_detect_i : event pulses
//   rstact_valid_i + rstact_def_i, rstact_clear_i, getstatus_i : CCC decoder events
//   is_in_hdr_mode_o, periph_reset_o, target_reset_o, rstact_o[1:0], esc_armed_o
module i3c_target_reset_ctrl #(
  parameter int PULSE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       hdr_enter_i,
  input  logic       hdr_exit_detect_i,
  input  logic       target_reset_detect_i,
  input  logic       rstact_valid_i,
  input  logic [7:0] rstact_def_i,
  input  logic       rstact_clear_i,
  input  logic       getstatus_i,
  output logic       is_in_hdr_mode_o,
  output logic       periph_reset_o,
  output logic       target_reset_o,
  output logic [1:0] rstact_o,
  output logic       esc_armed_o
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRST = 2'd1;
  localparam logic [1:0] S_TRST = 2'd2;

  // Encoded RSTACT actions held in rstact_q
  localparam logic [1:0] ACT_NONE   = 2'd0;
  localparam logic [1:0] ACT_PERIPH = 2'd1;
  localparam logic [1:0] ACT_TARGET = 2'd2;
  localparam logic [1:0] ACT_NORST  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PULSE_CYCLES);

  logic [1:0]    state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [1:0]    rstact_q, rstact_nxt;
  logic          esc_q, esc_nxt;
  logic          hdr_q, hdr_nxt;
  logic          pattern_taken;

  // A reset pattern only matters when no pulse is already in flight.
  assign pattern_taken = target_reset_detect_i && (state_q == S_IDLE);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    esc_nxt   = esc_q;

    case (state_q)
      S_IDLE: begin
        cnt_nxt = '0;
        if (target_reset_detect_i) begin
          // Decision uses the RSTACT value held before this edge.
          case (rstact_q)
            ACT_TARGET: begin
              state_nxt = S_TRST;
              esc_nxt   = 1'b0;
            end
            ACT_PERIPH: begin
              state_nxt = S_PRST;
              esc_nxt   = 1'b0;
            end
            ACT_NORST: begin
              state_nxt = S_IDLE;
            end
            default: begin
              // Default action: first pattern resets the peripheral and arms
              // escalation; a second one without GETSTATUS resets the target.
              if (esc_q) begin
                state_nxt = S_TRST;
                esc_nxt   = 1'b0;
              end else begin
                state_nxt = S_PRST;
                esc_nxt   = 1'b1;
              end
            end
          endcase
        end
      end
      S_PRST, S_TRST: begin
        if (cnt_q == CNT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // GETSTATUS disarms escalation, overriding an arm on the same edge.
    if (getstatus_i) begin
      esc_nxt = 1'b0;
    end
  end

  // RSTACT setting: consumed by a taken pattern or expired by clear; a
  // recognised defining byte on the same edge takes precedence over both.
  always_comb begin
    rstact_nxt = rstact_q;
    if (pattern_taken || rstact_clear_i) begin
      rstact_nxt = ACT_NONE;
    end
    if (rstact_valid_i) begin
      case (rstact_def_i)
        8'h00:   rstact_nxt = ACT_NORST;
        8'h01:   rstact_nxt = ACT_PERIPH;
        8'h02:   rstact_nxt = ACT_TARGET;
        default: rstact_nxt = rstact_nxt;
      endcase
    end
  end

  // HDR flag: exit or reset pattern wins over a simultaneous enter.
  always_comb begin
    hdr_nxt = hdr_q;
    if (hdr_exit_detect_i || target_reset_detect_i) begin
      hdr_nxt = 1'b0;
    end else if (hdr_enter_i) begin
      hdr_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rstact_q <= ACT_NONE;
      esc_q    <= 1'b0;
      hdr_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      rstact_q <= rstact_nxt;
      esc_q    <= esc_nxt;
      hdr_q    <= hdr_nxt;
    end
  end

  assign is_in_hdr_mode_o = hdr_q;
  assign periph_reset_o   = (state_q == S_PRST);
  assign target_reset_o   = (state_q == S_TRST);
  assign rstact_o         = rstact_q;
  assign esc_armed_o      = esc_q;

endmodule
